ring_counter_sync: RTL and testbench

Parametrised ring-oscillator edge counter. It runs entirely in the ring_clk domain and replaces the bare free-running counter in the ring controller. It adds gated and single-shot measurement windows, saturating or wrapping arithmetic, and an overflow flag. For clean crossing into the bus clock domain it provides a Gray-coded live count and a toggle-handshake snapshot. The gate and snapshot-request inputs come from the bus-side CSR block and are synchronized internally.

---
 rtl/ring_counter_sync.sv | 139 +++++++++++++
 tb/tb_ring_counter_sync.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_counter_sync.sv
// Ring-oscillator edge counter with gated/single-shot windows,
// Gray-coded live count and toggle-handshake snapshot.
module ring_counter_sync #(
  parameter int COUNT_BITS  = 24,
  parameter int SYNC_STAGES = 2,
  parameter bit SATURATE    = 1'b1
) (
  input  logic                  ring_clk,
  input  logic                  counter_resetb,
  input  logic [1:0]            mode_i,
  input  logic                  gate_i,
  input  logic                  snap_req_i,
  output logic                  snap_ack_o,
  output logic [COUNT_BITS-1:0] snap_value_o,
  output logic [COUNT_BITS-1:0] count_gray_o,
  output logic                  overflow_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  localparam logic [COUNT_BITS-1:0] ALL_ONES = '1;
  localparam logic [COUNT_BITS-1:0] ONE = COUNT_BITS'(1);

  logic [SYNC_STAGES-1:0] gate_sync;
  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES:0]   fill;
  logic                   gate_d;
  logic                   req_d;
  logic                   gate_s;
  logic                   req_s;
  logic                   rise;
  logic                   snap_evt;
  logic [COUNT_BITS-1:0]  count;
  logic [COUNT_BITS-1:0]  count_inc;
  logic                   at_max;
  logic                   m_free;
  logic                   m_gated;
  logic                   m_shot;
  logic                   do_inc;
  state_t                 state;

  assign gate_s   = gate_sync[SYNC_STAGES-1];
  assign req_s    = req_sync[SYNC_STAGES-1];
  assign snap_evt = req_s ^ req_d;

  // gate_d only holds a real sample once the chain has refilled after
  // reset, so a gate left high across reset is not seen as a rise.
  assign rise = gate_s & ~gate_d & fill[SYNC_STAGES];

  assign at_max    = (count == ALL_ONES);
  assign count_inc = at_max ? (SATURATE ? ALL_ONES : '0) : count + ONE;

  assign m_free  = (mode_i == 2'd0);
  assign m_gated = (mode_i == 2'd1);
  assign m_shot  = (mode_i == 2'd2);

  always_comb begin
    do_inc = 1'b0;
    unique case (1'b1)
      m_free:  do_inc = 1'b1;
      m_gated: do_inc = gate_s;
      m_shot:  do_inc = gate_s & (state == S_COUNT);
      default: do_inc = 1'b0;
    endcase
  end

  always_ff @(posedge ring_clk or negedge counter_resetb) begin
    if (!counter_resetb) begin
      gate_sync <= '0;
      req_sync  <= '0;
      fill      <= '0;
      gate_d    <= 1'b0;
      req_d     <= 1'b0;
    end else begin
      gate_sync <= {gate_sync[SYNC_STAGES-2:0], gate_i};
      req_sync  <= {req_sync[SYNC_STAGES-2:0], snap_req_i};
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
      gate_d    <= gate_s;
      req_d     <= req_s;
    end
  end

  always_ff @(posedge ring_clk or negedge counter_resetb) begin
    if (!counter_resetb) begin
      count        <= '0;
      count_gray_o <= '0;
      snap_value_o <= '0;
      snap_ack_o   <= 1'b0;
      overflow_o   <= 1'b0;
      done_o       <= 1'b0;
      state        <= S_IDLE;
    end else begin
      count_gray_o <= count ^ (count >> 1);
      if (snap_evt) begin
        snap_value_o <= count;
        snap_ack_o   <= ~snap_ack_o;
      end
      if (do_inc) begin
        count <= count_inc;
        if (at_max) overflow_o <= 1'b1;
      end
      if (!m_shot) begin
        state  <= S_IDLE;
        done_o <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (rise) begin
              count      <= ONE;
              overflow_o <= 1'b0;
              state      <= S_COUNT;
            end
          end
          S_COUNT: begin
            if (!gate_s) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end
          end
          S_DONE: begin
            if (rise) begin
              count      <= ONE;
              overflow_o <= 1'b0;
              done_o     <= 1'b0;
              state      <= S_COUNT;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_counter_sync.sv
// Bench for ring_counter_sync: three configurations driven in parallel,
// checked every cycle against a window-level model plus literals.
module tb_ring_counter_sync;

  localparam int SS = 2;

  logic       ring_clk;
  logic       rstb;
  logic [1:0] mode;
  logic       gate;
  logic       req;

  logic        ack0, ack1, ack2;
  logic [7:0]  sv0, sv1, g0, g1;
  logic [23:0] sv2, g2;
  logic        ov0, ov1, ov2;
  logic        dn0, dn1, dn2;

  ring_counter_sync #(.COUNT_BITS(8), .SYNC_STAGES(SS), .SATURATE(1'b0)) u_wrap (
    .ring_clk(ring_clk), .counter_resetb(rstb), .mode_i(mode),
    .gate_i(gate), .snap_req_i(req), .snap_ack_o(ack0),
    .snap_value_o(sv0), .count_gray_o(g0), .overflow_o(ov0), .done_o(dn0));

  ring_counter_sync #(.COUNT_BITS(8), .SYNC_STAGES(SS), .SATURATE(1'b1)) u_sat (
    .ring_clk(ring_clk), .counter_resetb(rstb), .mode_i(mode),
    .gate_i(gate), .snap_req_i(req), .snap_ack_o(ack1),
    .snap_value_o(sv1), .count_gray_o(g1), .overflow_o(ov1), .done_o(dn1));

  ring_counter_sync #(.COUNT_BITS(24), .SYNC_STAGES(SS), .SATURATE(1'b1)) u_wide (
    .ring_clk(ring_clk), .counter_resetb(rstb), .mode_i(mode),
    .gate_i(gate), .snap_req_i(req), .snap_ack_o(ack2),
    .snap_value_o(sv2), .count_gray_o(g2), .overflow_o(ov2), .done_o(dn2));

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    ring_clk = 1'b0;
    forever #5 ring_clk = ~ring_clk;
  end

  int     W[3] = '{8, 8, 24};
  bit     S[3] = '{1'b0, 1'b1, 1'b1};
  longint m_cnt[3];
  longint m_gray[3];
  longint m_snap[3];
  bit     m_ovf[3];
  bit     m_done[3];
  bit     m_win[3];
  bit     m_ack;
  bit     gq[$];
  bit     rq[$];
  bit     gs, rs, rd, rise, sevt;
  longint pre, maxv;

  task automatic bump(input int i, input longint mx);
    if (m_cnt[i] == mx) begin
      m_ovf[i] = 1'b1;
      m_cnt[i] = S[i] ? mx : 0;
    end else begin
      m_cnt[i] = m_cnt[i] + 1;
    end
  endtask

  // gq/rq hold past input samples, newest first; an absent entry means
  // the synchronizer has not yet delivered a real sample since reset.
  initial begin
    forever begin
      @(posedge ring_clk or negedge rstb);
      if (!rstb) begin
        for (int i = 0; i < 3; i++) begin
          m_cnt[i] = 0; m_gray[i] = 0; m_snap[i] = 0;
          m_ovf[i] = 0; m_done[i] = 0; m_win[i] = 0;
        end
        m_ack = 0;
        gq.delete();
        rq.delete();
      end else begin
        gs   = (gq.size() >= SS) ? gq[SS-1] : 1'b0;
        rise = (gq.size() >= SS + 1) && gs && !gq[SS];
        rs   = (rq.size() >= SS) ? rq[SS-1] : 1'b0;
        rd   = (rq.size() >= SS + 1) ? rq[SS] : 1'b0;
        sevt = rs ^ rd;
        for (int i = 0; i < 3; i++) begin
          pre  = m_cnt[i];
          maxv = (64'd1 << W[i]) - 1;
          if (sevt) m_snap[i] = pre;
          m_gray[i] = pre ^ (pre >> 1);
          if (mode != 2'd2) begin
            m_win[i] = 0;
            m_done[i] = 0;
          end
          case (mode)
            2'd0: bump(i, maxv);
            2'd1: if (gs) bump(i, maxv);
            2'd2: begin
              if (m_win[i]) begin
                if (gs) bump(i, maxv);
                else begin
                  m_win[i] = 0;
                  m_done[i] = 1;
                end
              end else if (rise) begin
                m_cnt[i] = 1; m_ovf[i] = 0; m_done[i] = 0; m_win[i] = 1;
              end
            end
            default: ;
          endcase
        end
        if (sevt) m_ack = !m_ack;
        gq.push_front(gate);
        rq.push_front(req);
        if (gq.size() > SS + 1) void'(gq.pop_back());
        if (rq.size() > SS + 1) void'(rq.pop_back());
      end
    end
  end

  longint a_gray[3], a_snap[3];
  bit     a_ack[3], a_ovf[3], a_done[3];
  always_comb begin
    a_gray[0] = longint'(g0); a_gray[1] = longint'(g1); a_gray[2] = longint'(g2);
    a_snap[0] = longint'(sv0); a_snap[1] = longint'(sv1); a_snap[2] = longint'(sv2);
    a_ack[0] = ack0; a_ack[1] = ack1; a_ack[2] = ack2;
    a_ovf[0] = ov0; a_ovf[1] = ov1; a_ovf[2] = ov2;
    a_done[0] = dn0; a_done[1] = dn1; a_done[2] = dn2;
  end

  initial begin
    forever begin
      @(negedge ring_clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("gray%0d", i), a_gray[i], m_gray[i]);
        chk($sformatf("snap%0d", i), a_snap[i], m_snap[i]);
        chk($sformatf("ack%0d", i), longint'(a_ack[i]), longint'(m_ack));
        chk($sformatf("ovf%0d", i), longint'(a_ovf[i]), longint'(m_ovf[i]));
        chk($sformatf("done%0d", i), longint'(a_done[i]), longint'(m_done[i]));
      end
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge ring_clk);
    #2;
  endtask

  longint snap_a;

  initial begin
    rstb = 1'b1; mode = 2'd0; gate = 1'b0; req = 1'b0;
    #1 rstb = 1'b0;
    edges(2);
    chk("rst_gray", longint'(g2), 0);
    chk("rst_ack", longint'(ack2), 0);
    chk("rst_ovf", longint'(ov0), 0);
    edges(1);
    rstb = 1'b1;

    edges(300);
    edges(1);
    chk("wrap_gray", longint'(g0), 64'h3A);
    chk("wrap_ovf", longint'(ov0), 1);
    chk("sat_gray", longint'(g1), 64'h80);
    chk("sat_ovf", longint'(ov1), 1);
    chk("wide_gray", longint'(g2), 64'h1BA);
    chk("wide_ovf", longint'(ov2), 0);

    edges(699);
    req = 1'b1;
    edges(2);
    chk("ack_early", longint'(ack2), 0);
    edges(1);
    chk("ack_3rd", longint'(ack2), 1);
    chk("snap_1002", longint'(sv2), 1002);
    chk("snap_sat", longint'(sv1), 64'hFF);
    chk("snap_wrap", longint'(sv0), 234);
    edges(50);
    chk("snap_stable", longint'(sv2), 1002);

    mode = 2'd3;
    edges(3);
    req = 1'b0;
    edges(5);
    snap_a = longint'(sv2);
    mode = 2'd1;
    edges(2);
    gate = 1'b1; edges(20);
    gate = 1'b0; edges(10);
    gate = 1'b1; edges(15);
    gate = 1'b0; edges(10);
    mode = 2'd3;
    edges(2);
    req = 1'b1;
    edges(5);
    chk("gated_35", longint'(sv2) - snap_a, 35);
    chk("gated_done", longint'(dn2), 0);

    mode = 2'd2;
    edges(5);
    gate = 1'b1; edges(100);
    gate = 1'b0; edges(6);
    chk("win1_done", longint'(dn2), 1);
    chk("win1_gray", longint'(g2), 64'h56);
    chk("win1_gray8", longint'(g0), 64'h56);
    chk("win1_ovf", longint'(ov1), 0);
    gate = 1'b1; edges(10);
    chk("win2_busy", longint'(dn2), 0);
    edges(27);
    gate = 1'b0; edges(6);
    chk("win2_done", longint'(dn2), 1);
    chk("win2_gray", longint'(g2), 64'h37);

    gate = 1'b1; edges(20);
    rstb = 1'b0;
    #1;
    chk("mid_gray", longint'(g2), 0);
    chk("mid_snap", longint'(sv2), 0);
    chk("mid_ack", longint'(ack2), 0);
    chk("mid_done", longint'(dn2), 0);
    edges(3);
    rstb = 1'b1;
    edges(20);
    chk("held_gray", longint'(g2), 0);
    chk("held_done", longint'(dn2), 0);
    gate = 1'b0; edges(5);
    gate = 1'b1; edges(10);
    chk("rearm_gray", longint'(g2), 4);
    edges(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
